// File: rtl/morse_pkg.sv
// Shared constants, types and the ITU Morse ROM for the character encoder.
// ROM codes are stored left-justified (first symbol in bit 4, 1=dash) with unused bits zero.
package morse_pkg;

    localparam int MORSE_SYMS = 5;

    localparam logic [5:0] IDX_DIGIT0   = 6'd0;
    localparam logic [5:0] IDX_LETTER_A = 6'd10;
    localparam logic [5:0] IDX_MAX      = 6'd35;

    typedef logic [MORSE_SYMS-1:0] sym_vec_t;
    typedef logic [2:0]            sym_len_t;

    typedef struct packed {
        sym_vec_t code;
        sym_len_t len;
    } morse_entry_t;

    function automatic morse_entry_t morse_rom(input logic [5:0] idx);
        morse_entry_t e;
        e = '{code: '0, len: '0};
        case (idx)
            IDX_DIGIT0 + 6'd0:    e = '{code: 5'b11111, len: 3'd5};
            IDX_DIGIT0 + 6'd1:    e = '{code: 5'b01111, len: 3'd5};
            IDX_DIGIT0 + 6'd2:    e = '{code: 5'b00111, len: 3'd5};
            IDX_DIGIT0 + 6'd3:    e = '{code: 5'b00011, len: 3'd5};
            IDX_DIGIT0 + 6'd4:    e = '{code: 5'b00001, len: 3'd5};
            IDX_DIGIT0 + 6'd5:    e = '{code: 5'b00000, len: 3'd5};
            IDX_DIGIT0 + 6'd6:    e = '{code: 5'b10000, len: 3'd5};
            IDX_DIGIT0 + 6'd7:    e = '{code: 5'b11000, len: 3'd5};
            IDX_DIGIT0 + 6'd8:    e = '{code: 5'b11100, len: 3'd5};
            IDX_DIGIT0 + 6'd9:    e = '{code: 5'b11110, len: 3'd5};
            IDX_LETTER_A + 6'd0:  e = '{code: 5'b01000, len: 3'd2}; // A
            IDX_LETTER_A + 6'd1:  e = '{code: 5'b10000, len: 3'd4}; // B
            IDX_LETTER_A + 6'd2:  e = '{code: 5'b10100, len: 3'd4}; // C
            IDX_LETTER_A + 6'd3:  e = '{code: 5'b10000, len: 3'd3}; // D
            IDX_LETTER_A + 6'd4:  e = '{code: 5'b00000, len: 3'd1}; // E
            IDX_LETTER_A + 6'd5:  e = '{code: 5'b00100, len: 3'd4}; // F
            IDX_LETTER_A + 6'd6:  e = '{code: 5'b11000, len: 3'd3}; // G
            IDX_LETTER_A + 6'd7:  e = '{code: 5'b00000, len: 3'd4}; // H
            IDX_LETTER_A + 6'd8:  e = '{code: 5'b00000, len: 3'd2}; // I
            IDX_LETTER_A + 6'd9:  e = '{code: 5'b01110, len: 3'd4}; // J
            IDX_LETTER_A + 6'd10: e = '{code: 5'b10100, len: 3'd3}; // K
            IDX_LETTER_A + 6'd11: e = '{code: 5'b01000, len: 3'd4}; // L
            IDX_LETTER_A + 6'd12: e = '{code: 5'b11000, len: 3'd2}; // M
            IDX_LETTER_A + 6'd13: e = '{code: 5'b10000, len: 3'd2}; // N
            IDX_LETTER_A + 6'd14: e = '{code: 5'b11100, len: 3'd3}; // O
            IDX_LETTER_A + 6'd15: e = '{code: 5'b01100, len: 3'd4}; // P
            IDX_LETTER_A + 6'd16: e = '{code: 5'b11010, len: 3'd4}; // Q
            IDX_LETTER_A + 6'd17: e = '{code: 5'b01000, len: 3'd3}; // R
            IDX_LETTER_A + 6'd18: e = '{code: 5'b00000, len: 3'd3}; // S
            IDX_LETTER_A + 6'd19: e = '{code: 5'b10000, len: 3'd1}; // T
            IDX_LETTER_A + 6'd20: e = '{code: 5'b00100, len: 3'd3}; // U
            IDX_LETTER_A + 6'd21: e = '{code: 5'b00010, len: 3'd4}; // V
            IDX_LETTER_A + 6'd22: e = '{code: 5'b01100, len: 3'd3}; // W
            IDX_LETTER_A + 6'd23: e = '{code: 5'b10010, len: 3'd4}; // X
            IDX_LETTER_A + 6'd24: e = '{code: 5'b10110, len: 3'd4}; // Y
            IDX_LETTER_A + 6'd25: e = '{code: 5'b11000, len: 3'd4}; // Z
            default:              e = '{code: '0, len: '0};
        endcase
        return e;
    endfunction

    // L ones from the top bit downward; a zero length gives a blank mask.
    function automatic sym_vec_t len_mask(input sym_len_t len);
        sym_vec_t ones;
        ones = '1;
        return ~(ones >> len);
    endfunction

endpackage

// File: rtl/morse_symbol_demux.sv
// Per-position lamp driver: splits one enabled Morse symbol into dot and dash lamps.
module morse_symbol_demux (
    input  logic num,
    input  logic display,
    output logic ponto,
    output logic traco
);

    assign ponto = display & ~num;
    assign traco = display &  num;

endmodule

// File: rtl/codif_morse.sv
// Registered character-index to Morse encoder with left-justified symbols,
// position-enable mask and one dot/dash lamp driver per position.
module codif_morse
    import morse_pkg::*;
#(
    parameter int SYMS = MORSE_SYMS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      num,
    input  logic            ready,
    output logic [SYMS-1:0] morse,
    output logic [SYMS-1:0] display,
    output logic [SYMS-1:0] ponto,
    output logic [SYMS-1:0] traco
);

    morse_entry_t   w_entry;
    logic           w_valid;
    sym_vec_t       w_mask;
    sym_vec_t       w_code;

    logic [SYMS-1:0] r_morse;
    logic [SYMS-1:0] r_display;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_entry = morse_rom(num);
        w_valid = (num <= IDX_MAX);
        w_mask  = '0;
        if (w_valid) begin
            w_mask = len_mask(w_entry.len);
        end
        // Bits past the code length are forced to dot/off regardless of ROM content.
        w_code = w_entry.code & w_mask;
    end

    // NOTE: state uses non-blocking assignments; reset wins over a coincident load edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_morse   <= '0;
            r_display <= '0;
        end else if (ready) begin
            r_morse   <= w_code;
            r_display <= w_mask;
        end
    end

    assign morse   = r_morse;
    assign display = r_display;

    for (genvar i = 0; i < SYMS; i++) begin : g_lamp
        morse_symbol_demux u_demux (
            .num     (r_morse[i]),
            .display (r_display[i]),
            .ponto   (ponto[i]),
            .traco   (traco[i])
        );
    end

endmodule

// File: tb/tb_codif_morse.sv
// Directed self-checking bench for codif_morse: reset behaviour, digits, letters,
// full index sweep, hold on ready=0, invalid index and mid-sequence reset.
module tb_codif_morse;

    logic       clk;
    logic       reset;
    logic [5:0] num;
    logic       ready;
    logic [4:0] morse;
    logic [4:0] display;
    logic [4:0] ponto;
    logic [4:0] traco;

    int checks = 0;
    int errors = 0;

    // Hand-written ITU table, left-justified, 1=dash.
    localparam logic [4:0] EXP_M [36] = '{
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
        5'b01000, 5'b10000, 5'b10100, 5'b10000, 5'b00000, 5'b00100, // A-F
        5'b11000, 5'b00000, 5'b00000, 5'b01110, 5'b10100, 5'b01000, // G-L
        5'b11000, 5'b10000, 5'b11100, 5'b01100, 5'b11010, 5'b01000, // M-R
        5'b00000, 5'b10000, 5'b00100, 5'b00010, 5'b01100, 5'b10010, // S-X
        5'b10110, 5'b11000                                          // Y-Z
    };
    localparam logic [4:0] EXP_D [36] = '{
        5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111,
        5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111,
        5'b11000, 5'b11110, 5'b11110, 5'b11100, 5'b10000, 5'b11110, // A-F
        5'b11100, 5'b11110, 5'b11000, 5'b11110, 5'b11100, 5'b11110, // G-L
        5'b11000, 5'b11000, 5'b11100, 5'b11110, 5'b11110, 5'b11100, // M-R
        5'b11100, 5'b10000, 5'b11100, 5'b11110, 5'b11100, 5'b11110, // S-X
        5'b11110, 5'b11110                                          // Y-Z
    };

    codif_morse dut (
        .clk     (clk),
        .reset   (reset),
        .num     (num),
        .ready   (ready),
        .morse   (morse),
        .display (display),
        .ponto   (ponto),
        .traco   (traco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] m, input logic [4:0] d);
        check({tag, ".morse"},   morse,   m);
        check({tag, ".display"}, display, d);
        check({tag, ".ponto"},   ponto,   d & ~m);
        check({tag, ".traco"},   traco,   d & m);
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input logic [5:0] n, input logic rdy);
        @(negedge clk);
        num   = n;
        ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        ready = 1'b1;
        num   = 6'd5;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("in_reset%0d", k), 5'b00000, 5'b00000);
        end

        // Release just after an edge: that edge must not have loaded anything.
        reset = 1'b1;
        check_all("after_release", 5'b00000, 5'b00000);
        @(posedge clk);
        #1;
        check_all("first_load_5", 5'b00000, 5'b11111);

        step(6'd1, 1'b1);
        check_all("digit1", 5'b01111, 5'b11111);
        check("digit1.ponto_lit", ponto, 5'b10000);
        check("digit1.traco_lit", traco, 5'b01111);
        step(6'd0, 1'b1);
        check_all("digit0", 5'b11111, 5'b11111);
        step(6'd5, 1'b1);
        check_all("digit5", 5'b00000, 5'b11111);
        check("digit5.ponto_lit", ponto, 5'b11111);

        step(6'd10, 1'b1);
        check_all("A", 5'b01000, 5'b11000);
        step(6'd14, 1'b1);
        check_all("E", 5'b00000, 5'b10000);
        step(6'd29, 1'b1);
        check_all("T", 5'b10000, 5'b10000);
        step(6'd26, 1'b1);
        check_all("Q", 5'b11010, 5'b11110);
        check("Q.lamps_cover", ponto | traco, 5'b11110);
        step(6'd35, 1'b1);
        check_all("Z", 5'b11000, 5'b11110);
        check("Z.lamps_cover", ponto | traco, 5'b11110);

        for (int i = 0; i < 36; i++) begin
            step(6'(i), 1'b1);
            check_all($sformatf("sweep%0d", i), EXP_M[i], EXP_D[i]);
            check($sformatf("sweep%0d.exclusive", i), ponto & traco, 5'b00000);
        end

        step(6'd10, 1'b0);
        check_all("hold_a", 5'b11000, 5'b11110);
        step(6'd1, 1'b0);
        check_all("hold_b", 5'b11000, 5'b11110);

        step(6'd40, 1'b1);
        check_all("invalid40", 5'b00000, 5'b00000);
        step(6'd63, 1'b1);
        check_all("invalid63", 5'b00000, 5'b00000);

        // Mid-sequence reset clears outputs without waiting for a clock edge.
        step(6'd26, 1'b1);
        check_all("pre_reset_Q", 5'b11010, 5'b11110);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("async_clear", 5'b00000, 5'b00000);
        @(posedge clk);
        #1;
        check_all("reset_ignores_ready", 5'b00000, 5'b00000);
        reset = 1'b1;
        step(6'd9, 1'b1);
        check_all("post_reset_9", 5'b11110, 5'b11111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
